// File: rtl/rotor_stack_stepper_pkg.sv
// Shared constants and FSM state type for the rotor stack stepper.
package rotor_pkg;

  localparam int unsigned ALPHABET_DEFAULT = 26;
  localparam int unsigned POS_W_DEFAULT    = 5;

  localparam int unsigned NOTCH_I   = 16;
  localparam int unsigned NOTCH_II  = 4;
  localparam int unsigned NOTCH_III = 21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rotor_stack_stepper_if.sv
// Keypress handshake, load port and position bus between debouncer, stepper and datapath.
interface rotor_stack_stepper_if #(
  parameter int unsigned NUM_ROTORS = 3,
  parameter int unsigned POS_W      = 5
);
  logic                        load;
  logic [NUM_ROTORS*POS_W-1:0] init_pos;
  logic                        key_valid;
  logic                        key_ready;
  logic                        step_done;
  logic [NUM_ROTORS*POS_W-1:0] pos_out;

  modport master (
    output load, init_pos, key_valid,
    input  key_ready, step_done, pos_out
  );

  modport slave (
    input  load, init_pos, key_valid,
    output key_ready, step_done, pos_out
  );
endinterface

// File: rtl/rotor_stack_stepper_ring_pos.sv
// One rotor position register: load with out-of-range clamp to 0, single step with wrap.
module rotor_ring_pos #(
  parameter int unsigned     ALPHABET = 26,
  parameter int unsigned     POS_W    = 5,
  parameter logic [POS_W-1:0] NOTCH   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [POS_W-1:0] i_init,
  input  logic             i_step_en,
  output logic [POS_W-1:0] o_pos,
  output logic             o_at_notch
);

  localparam logic [POS_W-1:0] LAST = POS_W'(ALPHABET - 1);

  logic [POS_W-1:0] r_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos <= '0;
    end else if (i_load) begin
      r_pos <= (i_init > LAST) ? '0 : i_init;
    end else if (i_step_en) begin
      r_pos <= (r_pos == LAST) ? '0 : r_pos + 1'b1;
    end
  end

  assign o_pos      = r_pos;
  assign o_at_notch = (r_pos == NOTCH);

endmodule

// File: rtl/rotor_stack_stepper.sv
// Rotor stack stepper: IDLE/STEP/DONE handshake FSM plus notch-driven carry chain.
// Define ROTOR_DOUBLE_STEP_EN to enable the Enigma middle-rotor double-step.
module rotor_stack_stepper
  import rotor_pkg::*;
#(
  parameter int unsigned                  NUM_ROTORS = 3,
  parameter int unsigned                  ALPHABET   = ALPHABET_DEFAULT,
  parameter int unsigned                  POS_W      = POS_W_DEFAULT,
  parameter logic [NUM_ROTORS*POS_W-1:0] NOTCH_POS  =
    {5'(NOTCH_I), 5'(NOTCH_II), 5'(NOTCH_III)}
) (
  input logic             clk,
  input logic             reset,
  rotor_stack_stepper_if.slave bus
);

  state_t r_state;
  logic   r_key_ready;
  logic   r_step_done;

  logic [NUM_ROTORS-1:0]       w_notch;
  logic [NUM_ROTORS-1:0]       w_step;
  logic [NUM_ROTORS*POS_W-1:0] w_pos;
  logic                        w_load_en;
  logic                        w_lead_notch_unused;

  assign w_load_en           = (r_state == ST_IDLE) && bus.load;
  assign w_lead_notch_unused = w_notch[NUM_ROTORS-1];

  // Carry ripples only through rotors that are themselves stepping; the
  // double-step term lets a middle rotor at its notch push itself and its neighbour.
  always_comb begin
    w_step    = '0;
    w_step[0] = 1'b1;
    for (int unsigned i = 1; i < NUM_ROTORS; i++) begin
      w_step[i] = w_step[i-1] & w_notch[i-1];
`ifdef ROTOR_DOUBLE_STEP_EN
      if (i <= NUM_ROTORS - 2) begin
        w_step[i] = w_step[i] | w_notch[i];
      end
`endif
    end
  end

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_ring
    rotor_ring_pos #(
      .ALPHABET (ALPHABET),
      .POS_W    (POS_W),
      .NOTCH    (NOTCH_POS[g*POS_W +: POS_W])
    ) u_ring (
      .clk        (clk),
      .rst        (reset),
      .i_load     (w_load_en),
      .i_init     (bus.init_pos[g*POS_W +: POS_W]),
      .i_step_en  ((r_state == ST_STEP) && w_step[g]),
      .o_pos      (w_pos[g*POS_W +: POS_W]),
      .o_at_notch (w_notch[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_key_ready <= 1'b1;
      r_step_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.key_valid && !bus.load) begin
            r_state     <= ST_STEP;
            r_key_ready <= 1'b0;
          end
        end
        ST_STEP: begin
          r_state     <= ST_DONE;
          r_step_done <= 1'b1;
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_step_done <= 1'b0;
          r_key_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_step_done <= 1'b0;
          r_key_ready <= 1'b1;
        end
      endcase
    end
  end

  // A same-cycle load takes priority, so readiness is masked combinationally.
  assign bus.key_ready = r_key_ready & ~bus.load;
  assign bus.step_done = r_step_done;
  assign bus.pos_out   = w_pos;

endmodule

// File: tb/tb_rotor_stack_stepper.sv
// Directed self-checking bench for rotor_stack_stepper; expectations follow ROTOR_DOUBLE_STEP_EN.
module tb_rotor_stack_stepper;

  localparam int unsigned NR = 3;
  localparam int unsigned PW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rotor_stack_stepper_if #(.NUM_ROTORS(NR), .POS_W(PW)) bus ();
  rotor_stack_stepper_if #(.NUM_ROTORS(NR), .POS_W(PW)) wbus ();

  rotor_stack_stepper #(
    .NUM_ROTORS (NR),
    .ALPHABET   (26),
    .POS_W      (PW),
    .NOTCH_POS  ({5'd16, 5'd4, 5'd21})
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rotor_stack_stepper #(
    .NUM_ROTORS (NR),
    .ALPHABET   (26),
    .POS_W      (PW),
    .NOTCH_POS  ({5'd25, 5'd25, 5'd25})
  ) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (wbus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] pk(input int unsigned a2, input int unsigned a1,
                                     input int unsigned a0);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic load_main(input logic [14:0] v);
    @(negedge clk);
    bus.load     = 1'b1;
    bus.init_pos = v;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic press_main(input string tag, input logic [14:0] exp);
    @(negedge clk);
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, 32'(bus.step_done), 32'd1);
    chk({tag, "_pos"}, 32'(bus.pos_out), 32'(exp));
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(bus.key_ready), 32'd1);
  endtask

  initial begin
    int seen;
    int pulses;
    int pidx[3];

    reset          = 1'b1;
    bus.load       = 1'b0;
    bus.key_valid  = 1'b0;
    bus.init_pos   = '0;
    wbus.load      = 1'b0;
    wbus.key_valid = 1'b0;
    wbus.init_pos  = '0;

    repeat (2) @(negedge clk);
    chk("rst_pos", 32'(bus.pos_out), 32'd0);
    chk("rst_ready", 32'(bus.key_ready), 32'd1);
    chk("rst_done", 32'(bus.step_done), 32'd0);

    // Reset while in STEP: the pending step is dropped.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("midstep_busy", 32'(bus.key_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_pos", 32'(bus.pos_out), 32'd0);
    chk("midrst_done", 32'(bus.step_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.key_ready), 32'd1);
    chk("midrst_nodone", 32'(bus.step_done), 32'd0);
    chk("midrst_pos2", 32'(bus.pos_out), 32'd0);
    @(negedge clk);
    chk("midrst_nodone2", 32'(bus.step_done), 32'd0);

    // A D U then three keys.
    load_main(pk(0, 3, 20));
    chk("load_adu", 32'(bus.pos_out), 32'(pk(0, 3, 20)));
    press_main("k1", pk(0, 3, 21));
    press_main("k2", pk(0, 4, 22));
`ifdef ROTOR_DOUBLE_STEP_EN
    press_main("k3", pk(1, 5, 23));
`else
    press_main("k3", pk(0, 4, 23));
`endif

    // Full carry chain with wrap on the all-notch-25 instance.
    @(negedge clk);
    wbus.load     = 1'b1;
    wbus.init_pos = pk(25, 25, 25);
    @(negedge clk);
    wbus.load = 1'b0;
    chk("wrap_load", 32'(wbus.pos_out), 32'(pk(25, 25, 25)));
    @(negedge clk);
    wbus.key_valid = 1'b1;
    @(negedge clk);
    wbus.key_valid = 1'b0;
    @(negedge clk);
    chk("wrap_done", 32'(wbus.step_done), 32'd1);
    chk("wrap_pos", 32'(wbus.pos_out), 32'd0);

    // Out-of-range slice clamps independently.
    load_main(pk(7, 27, 9));
    chk("clamp", 32'(bus.pos_out), 32'(pk(7, 0, 9)));

    // load and key_valid together: load wins, no step follows.
    @(negedge clk);
    bus.load      = 1'b1;
    bus.key_valid = 1'b1;
    bus.init_pos  = pk(1, 2, 3);
    #1;
    chk("collide_ready", 32'(bus.key_ready), 32'd0);
    @(negedge clk);
    bus.load      = 1'b0;
    bus.key_valid = 1'b0;
    chk("collide_pos", 32'(bus.pos_out), 32'(pk(1, 2, 3)));
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.step_done) seen++;
    end
    chk("collide_nodone", 32'(seen), 32'd0);
    chk("collide_pos2", 32'(bus.pos_out), 32'(pk(1, 2, 3)));

    // key_valid held for 9 cycles.
    load_main(pk(0, 0, 0));
    @(negedge clk);
    bus.key_valid = 1'b1;
    pulses = 0;
    pidx   = '{0, 0, 0};
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bus.step_done) begin
        if (pulses < 3) pidx[pulses] = k;
        pulses++;
      end
    end
    bus.key_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.step_done) pulses++;
    end
    chk("hold_pulses", 32'(pulses), 32'd3);
    chk("hold_gap1", 32'(pidx[1] - pidx[0]), 32'd3);
    chk("hold_gap2", 32'(pidx[2] - pidx[1]), 32'd3);
    chk("hold_pos", 32'(bus.pos_out), 32'(pk(0, 0, 3)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
